// File: rtl/trace_feeder_if.sv
// Record-in / access-out bundle for trace_feeder.
// slave is the feeder side, master is the trace source / cache side.
interface trace_feeder_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_op;
   logic [47:0] in_addr;
   logic [47:0] cache_addr;
   logic [7:0]  cache_op;
   logic        issue;

   modport master (
      output in_valid, in_op, in_addr,
      input  in_ready, cache_addr, cache_op, issue
   );

   modport slave (
      input  in_valid, in_op, in_addr,
      output in_ready, cache_addr, cache_op, issue
   );
endinterface

// File: rtl/trace_feeder.sv
// Trace feeder: buffers normalised trace records in a circular FIFO
// and issues them to the cache engine no closer than ISSUE_GAP cycles.
module trace_feeder #(
   parameter int FIFO_DEPTH = 8,
   parameter int ISSUE_GAP  = 2
) (
   input  logic           clk,
   input  logic           reset,
   trace_feeder_if.slave  bus,
   output logic           drained,
   output logic [11:0]    issued_count,
   output logic [11:0]    invalid_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
   localparam int GAP_LOAD = (ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_GAP} state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic [GW-1:0] r_gap_cnt;
   logic [GW-1:0] w_gap_nx;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [47:0]   r_mem_addr [FIFO_DEPTH];
   logic [7:0]    r_mem_op   [FIFO_DEPTH];

   logic [47:0]   r_cache_addr;
   logic [7:0]    r_cache_op;
   logic          r_issue;
   logic [11:0]   r_issued;
   logic [11:0]   r_invalid;

   logic          w_ready;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_op_ok;
   logic [7:0]    w_norm_op;

   // Map upper/lower case r/w onto the lowercase code the engine expects
   always_comb begin
      w_op_ok   = 1'b1;
      w_norm_op = 8'h00;
      unique case (bus.in_op)
         8'h72, 8'h52: w_norm_op = 8'h72;
         8'h77, 8'h57: w_norm_op = 8'h77;
         default:      w_op_ok   = 1'b0;
      endcase
   end

   // Ready looks only at the registered occupancy, so a pop never
   // frees a slot in the same cycle it happens.
   assign w_ready  = !reset && (r_count < DEPTH_C);
   assign w_accept = bus.in_valid && w_ready;
   assign w_push   = w_accept && w_op_ok;

   // Next-state logic: pop in IDLE, then wait out the issue gap
   always_comb begin
      w_state_nx = r_state;
      w_gap_nx   = r_gap_cnt;
      w_pop      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop = 1'b1;
               if (ISSUE_GAP > 1) begin
                  w_state_nx = S_GAP;
                  w_gap_nx   = GW'(GAP_LOAD);
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt == '0) w_state_nx = S_IDLE;
            else                 w_gap_nx   = r_gap_cnt - GW'(1);
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_gap_cnt <= w_gap_nx;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth wraps naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   // FIFO storage, holds already-normalised ops
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= bus.in_addr;
         r_mem_op[r_wr_ptr]   <= w_norm_op;
      end
   end

   // Access outputs hold their value until the next issue
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cache_addr <= '0;
         r_cache_op   <= 8'h00;
         r_issue      <= 1'b0;
      end else begin
         r_issue <= w_pop;
         if (w_pop) begin
            r_cache_addr <= r_mem_addr[r_rd_ptr];
            r_cache_op   <= r_mem_op[r_rd_ptr];
         end
      end
   end

   // Saturating issue / bad-op counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_issued  <= '0;
         r_invalid <= '0;
      end else begin
         if (w_pop && r_issued != 12'hFFF)
            r_issued <= r_issued + 12'd1;
         if (w_accept && !w_op_ok && r_invalid != 12'hFFF)
            r_invalid <= r_invalid + 12'd1;
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.cache_addr = r_cache_addr;
   assign bus.cache_op   = r_cache_op;
   assign bus.issue      = r_issue;
   assign issued_count   = r_issued;
   assign invalid_count  = r_invalid;
   assign drained = (r_count == '0) && (r_state == S_IDLE) && !r_issue;

endmodule
